perf_monitor_unit: RTL
======================

// Module: perf_monitor_unit
// PURPOSE
//  Synthesizable, parametrised performance monitor for the pipelined core.
//  Replaces the count logic that lives only in the bench. Counts cycles,
//  retired instructions and NUM_EVT generic events (I/D cache req/hit, stalls).
//  Freezes on halt and streams every counter out over a valid/ready dump port.
//  Sits beside proc, fed from the writeback/memory stage and the cache
//  controllers.
// PARAMETERS
//  NUM_EVT   4   number of generic event inputs
//  CNT_W     32  width of every counter
//  SATURATE  0   0: counters wrap to 0 on overflow; 1: counters hold at all-ones
//  NUM_CNT   (localparam) NUM_EVT+2; IDX_W (localparam) = clog2(NUM_CNT)
// PORTS
//  clk         in   1            core clock
//  rst         in   1            synchronous, active-high reset
//  en          in   1            counting enable, sampled each cycle
//  clr         in   1            synchronous clear of counters and ovf; re-arms monitor
//  ret_regwrt  in   1            register-file write retiring this cycle
//  ret_memwrt  in   1            memory write retiring this cycle
//  halt        in   1            halt in memory/writeback this cycle
//  evt         in   NUM_EVT      per-cycle event strobes
//  rd_sel      in   IDX_W        random-access counter select
//  rd_data     out  CNT_W        counter[rd_sel]; 0 if rd_sel >= NUM_CNT
//  ovf         out  NUM_CNT      sticky overflow flag per counter
//  frozen      out  1            high once halt is accepted
//  dump_valid  out  1            dump beat valid
//  dump_ready  in   1            consumer accepts beat
//  dump_idx    out  IDX_W        counter index of current beat
//  dump_data   out  CNT_W        counter value of current beat
//  dump_last   out  1            current beat is index NUM_CNT-1
// BEHAVIOUR
//  Counter map: 0 = cycles, 1 = retired insts, 2+i = evt[i].
//  Reset: counters 0, ovf 0, state RUN, frozen 0, dump_valid 0, dump_idx 0.
//  Priority: rst > clr > counting/FSM. Events in a clr cycle are dropped.
//  RUN, en=1: cycle +1; inst +1 if halt|ret_regwrt|ret_memwrt; cnt[2+i] +1 if
//   evt[i]. Multiple increments in the same cycle are all counted.
//  RUN, en=0: no counting. halt is ignored.
//  RUN, en=1, halt=1: that cycle still counts, including halt as one inst.
//   Next state is DUMP, and frozen=1 from the next cycle.
//  DUMP: dump_valid=1. dump_data = counter[dump_idx], combinational from the
//   frozen counter. A beat transfers on dump_valid & dump_ready, then dump_idx
//   +1. While ~dump_ready, dump_idx and dump_data hold stable.
//   dump_last = (dump_idx == NUM_CNT-1). A transfer with dump_last set goes
//   to DONE.
//  DONE: frozen=1, dump_valid=0. Stays until clr or rst.
//  halt in DUMP or DONE is ignored. Counters never change outside RUN.
//  clr in any state: counters 0, ovf 0, dump_idx 0, state RUN, frozen 0 and
//   dump_valid 0 on the next cycle.
//  Overflow: an increment at all-ones sets ovf[k] (sticky). SATURATE=0 wraps
//   the counter to 0; SATURATE=1 holds it at all-ones.
//  rd_data is combinational and valid in every state.
//  Latency: event at edge N is visible on rd_data after edge N.
// STRUCTURE
//  Shared package perf_pkg: state encoding (RUN/DUMP/DONE) and counter index
//   constants CNT_CYCLE=0, CNT_INST=1, CNT_EVT0=2.
//  Sub-module perf_ctr: one CNT_W counter with inc, clr, SATURATE and a sticky
//   ovf. Instantiated NUM_CNT times by generate.
//  Top level holds the FSM, dump_idx register and read/dump muxes.
// TESTING
//  1 rst, then en=1 for 10 cycles with ret_regwrt on cycles 2 and 5
//    -> cnt0=10, cnt1=2, ovf=0.
//  2 CNT_W=4, SATURATE=0, 17 cycles -> cnt0=1, ovf[0]=1.
//    Same with SATURATE=1 -> cnt0=15, ovf[0]=1.
//  3 halt on cycle 7, dump_ready=1 -> cnt0=7, cnt1=1.
//    Beats idx 0..NUM_CNT-1 on consecutive cycles, dump_last only on the last
//    beat, then DONE. Later evt strobes do not change rd_data.
//  4 dump_ready low for 3 cycles at idx 2 -> idx=2 and data held for 3 cycles.
//    Transfer on the 4th cycle.
//  5 clr at idx 3 during DUMP -> next cycle RUN, all counters 0, dump_valid 0,
//    frozen 0.
//    clr with evt[0]=1 in the same cycle -> cnt2=0.
//  6 rst mid-DUMP with ovf set -> all outputs at reset values the next cycle.
//    A second halt after re-run dumps fresh counts.

Source files
------------

// File: rtl/perf_monitor_unit_pkg.sv
// perf_pkg: shared definitions for the performance monitor.
//   perfState_t : monitor FSM states (RUN counts, DUMP streams, DONE idles frozen)
//   CNT_*       : fixed counter slots; generic events occupy CNT_EVT0 upward
package perf_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } perfState_t;

  localparam int CNT_CYCLE = 0;
  localparam int CNT_INST  = 1;
  localparam int CNT_EVT0  = 2;

endpackage

// File: rtl/perf_monitor_unit_ctr.sv
// perf_ctr: one CNT_W event counter with a sticky overflow flag.
//   clk, rst : clock and synchronous active-high reset
//   clr      : synchronous clear of count and ovf
//   inc      : add one this cycle
//   count    : current counter value
//   ovf      : set by any increment applied while count is all-ones
// SATURATE=0 wraps to zero on overflow, SATURATE=1 holds at all-ones.
module perf_ctr #(
  parameter int CNT_W    = 32,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  function automatic logic [CNT_W-1:0] nextCount(input logic [CNT_W-1:0] cur);
    if (cur == ALL_ONES) begin
      return (SATURATE != 0) ? ALL_ONES : '0;
    end
    return cur + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      count <= nextCount(count);
      if (count == ALL_ONES) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_monitor_unit.sv
// perf_monitor_unit: cycle / retired-instruction / generic-event counters for
// the pipelined core. Counting stops when a halt is accepted, after which every
// counter is streamed out once over a valid/ready dump port.
//   clk, rst               : clock, synchronous active-high reset
//   en                     : counting enable
//   clr                    : clear counters and ovf, return to counting
//   ret_regwrt, ret_memwrt : instruction retiring via register/memory write
//   halt                   : halt reaching memory/writeback (counts as one inst)
//   evt                    : NUM_EVT per-cycle event strobes
//   rd_sel / rd_data       : random-access counter read (0 when out of range)
//   ovf                    : sticky per-counter overflow
//   frozen                 : counters frozen after halt
//   dump_valid/ready/idx/data/last : counter dump stream
// Counter map: 0 = cycles, 1 = retired insts, 2+i = evt[i].
module perf_monitor_unit
  import perf_pkg::*;
#(
  parameter  int NUM_EVT  = 4,
  parameter  int CNT_W    = 32,
  parameter  int SATURATE = 0,
  localparam int NUM_CNT  = NUM_EVT + 2,
  localparam int IDX_W    = $clog2(NUM_CNT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic               ret_regwrt,
  input  logic               ret_memwrt,
  input  logic               halt,
  input  logic [NUM_EVT-1:0] evt,
  input  logic [IDX_W-1:0]   rd_sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic [NUM_CNT-1:0] ovf,
  output logic               frozen,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [IDX_W-1:0]   dump_idx,
  output logic [CNT_W-1:0]   dump_data,
  output logic               dump_last
);

  perfState_t           state;
  perfState_t           stateNext;
  logic [IDX_W-1:0]     dumpIdx;
  logic                 dumpLast;
  logic                 countEn;
  logic [NUM_CNT-1:0]   inc;
  logic [CNT_W-1:0]     cnt [NUM_CNT];

  // Counting only happens in RUN; this also freezes counters during DUMP/DONE.
  assign countEn = (state == ST_RUN) && en;

  always_comb begin
    inc            = '0;
    inc[CNT_CYCLE] = countEn;
    inc[CNT_INST]  = countEn && (halt || ret_regwrt || ret_memwrt);
    for (int i = 0; i < NUM_EVT; i++) begin
      inc[CNT_EVT0 + i] = countEn && evt[i];
    end
  end

  for (genvar k = 0; k < NUM_CNT; k++) begin : gCtr
    perf_ctr #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) uCtr (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (inc[k]),
      .count (cnt[k]),
      .ovf   (ovf[k])
    );
  end

  // FSM state register; clr re-arms the monitor from any state.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= ST_RUN;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_RUN:  if (en && halt)              stateNext = ST_DUMP;
      ST_DUMP: if (dump_ready && dumpLast)  stateNext = ST_DONE;
      ST_DONE: stateNext = ST_DONE;
      default: stateNext = ST_RUN;
    endcase
  end

  always_comb begin
    frozen     = (state != ST_RUN);
    dump_valid = (state == ST_DUMP);
  end

  assign dumpLast  = (dumpIdx == IDX_W'(NUM_CNT - 1));
  assign dump_last = dumpLast;
  assign dump_idx  = dumpIdx;

  // The index parks on the final slot after the last beat rather than
  // stepping past the counter range.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      dumpIdx <= '0;
    end else if (dump_valid && dump_ready && !dumpLast) begin
      dumpIdx <= dumpIdx + 1'b1;
    end
  end

  // Select loops instead of direct indexing so out-of-range selects read 0.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (rd_sel == IDX_W'(k)) rd_data = cnt[k];
    end
  end

  always_comb begin
    dump_data = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (dumpIdx == IDX_W'(k)) dump_data = cnt[k];
    end
  end

endmodule
